operand_fetch_seq: RTL and testbench
====================================

# operand_fetch_seq

Parametrised instruction/operand fetch sequencer that supersedes the ad-hoc fetch logic in the CPU front end. It reads one opcode plus 0–2 operand bytes from memory through a single read port and resolves every group-01 addressing mode into an effective address. Indirect pointer reads and index additions are handled internally, including the extra fix-up cycle when indexing crosses a page. It sits between the memory bus and the decoder/ALU, and hands over one complete instruction per `start`/`ready` handshake.

## Interface
- `REG_WIDTH`, 8: data/index width.
- `ADDR_WIDTH`, 16: address width; must equal 2*`REG_WIDTH`.
- `RESET_PC`, 16'h0600: PC value after reset.
- `clk` in 1: clock; all state updates on rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `start` in 1: request fetch of next instruction; accepted only in IDLE or DONE.
- `mem_rdata` in `REG_WIDTH`: read data; combinational from `mem_addr`, sampled at same edge.
- `x_reg`, `y_reg` in `REG_WIDTH`: index register values, sampled when used.
- `mem_rd` out 1: high in every state that samples `mem_rdata`.
- `mem_addr` out `ADDR_WIDTH`: read address.
- `pc` out `ADDR_WIDTH`: program counter, points past last consumed byte.
- `opcode` out `REG_WIDTH`, `imm` out `REG_WIDTH`, `ea` out `ADDR_WIDTH`: fetched instruction fields.
- `ea_valid` out 1: mode produces an effective address (all but IMM/implied).
- `page_cross` out 1: indexed add carried into the high byte.
- `ready` out 1: level, high in DONE.
- `busy` out 1: high from OPC until DONE.
- `fetch_cycles` out 3: cycles spent, OPC through last fetch state.

## Operation
- States: IDLE, OPC, OP1, OP2, IDX, PTR_LO, PTR_HI, FIX, DONE.
- IDLE/DONE + `start`: go to OPC next cycle. `start` in any other state is ignored.
- OPC: `mem_addr`=`pc`, capture `opcode`, `pc`++.
- If `opcode[1:0]`≠2'b01, the instruction is implied: go to DONE.
- Otherwise the mode is `opcode[4:2]`: 000 (zp,X), 001 zp, 010 #imm, 011 abs, 100 (zp),Y, 101 zp,X, 110 abs,Y, 111 abs,X.
- OP1 (`mem_addr`=`pc`, `pc`++):
  - imm: `imm`=byte, then DONE.
  - zp: `ea`={00,byte}, then DONE.
  - zp,X and (zp,X): latch byte, then IDX.
  - (zp),Y: `ptr`=byte, then PTR_LO.
  - abs modes: `ea[7:0]`=byte, then OP2.
- OP2 (`mem_addr`=`pc`, `pc`++):
  - abs: `ea[15:8]`=byte, then DONE.
  - abs,X/Y: `ea[15:8]`=byte, `{c,ea[7:0]}`=lo+idx. If c=1, set `page_cross` and go to FIX; otherwise DONE.
- IDX (no read, `mem_rd`=0): `t`=(zp+X) mod 256.
  - zp,X: `ea`={00,t}, then DONE.
  - (zp,X): `ptr`=t, then PTR_LO.
- PTR_LO: `mem_addr`={00,ptr}, `ea[7:0]`=byte.
- PTR_HI: `mem_addr`={00,(ptr+1) mod 256}, `ea[15:8]`=byte.
  - (zp),Y: add Y into low byte exactly as in the abs,X/Y step of OP2.
- FIX: `ea[15:8]`++ (mod 256), then DONE.
- Zero-page arithmetic always wraps within page 0. `pc` wraps FFFF→0000. `ea` high-byte fix-up wraps FF→00.
- Total cycles:
  - implied 1
  - imm/zp 2
  - zp,X/abs 3
  - abs,X/Y 3, or 4 on page cross
  - (zp),Y 4, or 5 on page cross
  - (zp,X) 5

## Timing
- Reset (`reset_n`=0 at edge, any state including mid-fetch):
  - state=IDLE, `pc`=`RESET_PC`.
  - `opcode`/`imm`/`ea`/`mem_addr`=0.
  - `mem_rd`/`ready`/`busy`/`ea_valid`/`page_cross`=0, `fetch_cycles`=0.
- `ready` rises the edge after the last fetch state and holds until `start` is accepted.
- Outputs are stable while `ready`=1.
- `page_cross`, `ea_valid` and `fetch_cycles` are cleared on entry to OPC.
- Back-to-back: `start` held high in DONE gives DONE→OPC with no idle cycle.
- `mem_rd` is combinationally derived from state; no other outputs change between edges.

## Structure
- Shared package `fetch_pkg` holds:
  - addressing-mode localparams (`AM_X_IND` … `AM_ABS_X`);
  - the state enum;
  - `RESET_PC` default;
  - the group-01 mask.
- One sub-module, `page_adder`: 8-bit base + 8-bit index, producing sum and carry. It is reused for IDX, OP2 and PTR_HI.

## Test plan
- Reset mid-fetch: `reset_n`=0 during OP2 → next cycle IDLE, `pc`=0600, `ready`=0. A following `start` fetches from 0600.
- LDA #$42 (A9 42 at 0600) → `opcode`=A9, `imm`=42, `ea_valid`=0, `pc`=0602, `fetch_cycles`=2.
- LDA $12F0,X (BD F0 12), X=$20 → `ea`=1310, `page_cross`=1, 4 cycles. With X=$05 → `ea`=12F5, 3 cycles.
- LDA ($FF,X) (A1 FF), X=$01, mem[00]=34, mem[01]=12 → `ea`=1234, 5 cycles; pointer wraps within zero page.
- LDA ($FF),Y (B1 FF), Y=$10, mem[FF]=F8, mem[00]=20 → `ea`=2108, `page_cross`=1, 5 cycles.
- Implied EA at FFFF with `start` held → `pc` wraps to 0000, 1 cycle. Next opcode is read from 0000 with no idle cycle; `start` during `busy` is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the operand fetch sequencer:
// addressing modes, FSM states and reset defaults.
package fetch_pkg;

  localparam logic [2:0] AM_X_IND = 3'd0;
  localparam logic [2:0] AM_ZP    = 3'd1;
  localparam logic [2:0] AM_IMM   = 3'd2;
  localparam logic [2:0] AM_ABS   = 3'd3;
  localparam logic [2:0] AM_IND_Y = 3'd4;
  localparam logic [2:0] AM_ZP_X  = 3'd5;
  localparam logic [2:0] AM_ABS_Y = 3'd6;
  localparam logic [2:0] AM_ABS_X = 3'd7;

  localparam logic [15:0] RESET_PC_DEF = 16'h0600;

  localparam logic [1:0] GRP_MASK = 2'b11;
  localparam logic [1:0] GRP01    = 2'b01;

  typedef enum logic [3:0] {
    IDLE,
    OPC,
    OP1,
    OP2,
    IDX,
    PTR_LO,
    PTR_HI,
    FIX,
    DONE
  } state_t;

  function automatic logic is_grp01(input logic [1:0] cc);
    return (cc & GRP_MASK) == GRP01;
  endfunction

endpackage

// File: rtl/page_adder.sv
// Byte-wide base + index adder; carry flags a page crossing.
module page_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] base_i,
  input  logic [W-1:0] idx_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  assign {carry_o, sum_o} = {1'b0, base_i} + {1'b0, idx_i};

endmodule

// File: rtl/operand_fetch_seq.sv
// Opcode/operand fetch sequencer resolving group-01
// addressing modes into an effective address.
module operand_fetch_seq
  import fetch_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic [REG_WIDTH-1:0]  x_reg,
  input  logic [REG_WIDTH-1:0]  y_reg,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [REG_WIDTH-1:0]  opcode,
  output logic [REG_WIDTH-1:0]  imm,
  output logic [ADDR_WIDTH-1:0] ea,
  output logic                  ea_valid,
  output logic                  page_cross,
  output logic                  ready,
  output logic                  busy,
  output logic [2:0]            fetch_cycles
);

  localparam int R = REG_WIDTH;
  localparam logic [R-1:0] ZP = '0;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  logic [R-1:0]          opc_q, opc_d;
  logic [R-1:0]          imm_q, imm_d;
  logic [R-1:0]          ptr_q, ptr_d;
  logic                  eav_q, eav_d;
  logic                  pgx_q, pgx_d;
  logic [2:0]            cyc_q, cyc_d;

  logic [2:0]   mode;
  logic [R-1:0] add_a, add_b, add_sum;
  logic         add_c;
  logic [R-1:0] ptr_inc;
  logic [R-1:0] ea_hi, ea_lo;

  assign mode    = opc_q[4:2];
  assign ptr_inc = ptr_q + R'(1);
  assign ea_hi   = ea_q[ADDR_WIDTH-1:R];
  assign ea_lo   = ea_q[R-1:0];

  // One adder serves zp+X, abs+X/Y and (zp)+Y
  assign add_a = (state_q == IDX) ? ptr_q : ea_lo;
  assign add_b = (state_q == IDX || mode == AM_ABS_X)
               ? x_reg : y_reg;

  page_adder #(.W(R)) u_add (
    .base_i  (add_a),
    .idx_i   (add_b),
    .sum_o   (add_sum),
    .carry_o (add_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      ea_q    <= '0;
      opc_q   <= '0;
      imm_q   <= '0;
      ptr_q   <= '0;
      eav_q   <= 1'b0;
      pgx_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ea_q    <= ea_d;
      opc_q   <= opc_d;
      imm_q   <= imm_d;
      ptr_q   <= ptr_d;
      eav_q   <= eav_d;
      pgx_q   <= pgx_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ea_d    = ea_q;
    opc_d   = opc_q;
    imm_d   = imm_q;
    ptr_d   = ptr_q;
    eav_d   = eav_q;
    pgx_d   = pgx_q;
    cyc_d   = busy ? cyc_q + 3'd1 : cyc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = OPC;
          eav_d   = 1'b0;
          pgx_d   = 1'b0;
          cyc_d   = '0;
        end
      end
      OPC: begin
        opc_d = mem_rdata;
        pc_d  = pc_q + ADDR_WIDTH'(1);
        if (is_grp01(mem_rdata[1:0])) begin
          state_d = OP1;
          eav_d   = mem_rdata[4:2] != AM_IMM;
        end else begin
          state_d = DONE;
        end
      end
      OP1: begin
        pc_d = pc_q + ADDR_WIDTH'(1);
        unique case (mode)
          AM_IMM: begin
            imm_d   = mem_rdata;
            state_d = DONE;
          end
          AM_ZP: begin
            ea_d    = {ZP, mem_rdata};
            state_d = DONE;
          end
          AM_ZP_X, AM_X_IND: begin
            ptr_d   = mem_rdata;
            state_d = IDX;
          end
          AM_IND_Y: begin
            ptr_d   = mem_rdata;
            state_d = PTR_LO;
          end
          default: begin
            ea_d    = {ea_hi, mem_rdata};
            state_d = OP2;
          end
        endcase
      end
      OP2: begin
        pc_d = pc_q + ADDR_WIDTH'(1);
        if (mode == AM_ABS) begin
          ea_d    = {mem_rdata, ea_lo};
          state_d = DONE;
        end else begin
          ea_d    = {mem_rdata, add_sum};
          pgx_d   = add_c;
          state_d = add_c ? FIX : DONE;
        end
      end
      IDX: begin
        if (mode == AM_ZP_X) begin
          ea_d    = {ZP, add_sum};
          state_d = DONE;
        end else begin
          ptr_d   = add_sum;
          state_d = PTR_LO;
        end
      end
      PTR_LO: begin
        ea_d    = {ea_hi, mem_rdata};
        state_d = PTR_HI;
      end
      PTR_HI: begin
        if (mode == AM_IND_Y) begin
          ea_d    = {mem_rdata, add_sum};
          pgx_d   = add_c;
          state_d = add_c ? FIX : DONE;
        end else begin
          ea_d    = {mem_rdata, ea_lo};
          state_d = DONE;
        end
      end
      FIX: begin
        ea_d    = {ea_hi + R'(1), ea_lo};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Address is registered so it is valid for the whole read state
    unique case (state_d)
      OPC, OP1, OP2: addr_d = pc_d;
      PTR_LO:        addr_d = {ZP, ptr_d};
      PTR_HI:        addr_d = {ZP, ptr_inc};
      default:       addr_d = addr_q;
    endcase
  end

  always_comb begin
    mem_rd = 1'b0;
    busy   = 1'b0;
    ready  = 1'b0;
    unique case (state_q)
      OPC, OP1, OP2, PTR_LO, PTR_HI: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
      end
      IDX, FIX: busy  = 1'b1;
      DONE:     ready = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr     = addr_q;
  assign pc           = pc_q;
  assign opcode       = opc_q;
  assign imm          = imm_q;
  assign ea           = ea_q;
  assign ea_valid     = eav_q;
  assign page_cross   = pgx_q;
  assign fetch_cycles = cyc_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Scoreboard bench for operand_fetch_seq against a
// byte-level model of the addressing modes.
module tb_operand_fetch_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, w_start;
  logic [7:0]  x, y;
  logic [7:0]  mem_rdata, w_rdata;
  logic        mem_rd, ready, busy, ea_valid, page_cross;
  logic [15:0] mem_addr, pc, ea;
  logic [7:0]  opcode, imm;
  logic [2:0]  fetch_cycles;
  logic        w_rd, w_ready, w_busy, w_eav, w_pgx;
  logic [15:0] w_addr, w_pc, w_ea;
  logic [7:0]  w_opc, w_imm;
  logic [2:0]  w_cyc;

  logic [7:0] mem [0:65535];

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  imm;
    logic [15:0] ea;
    logic [15:0] pc;
    bit          ev;
    bit          pcx;
    bit          is_imm;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] pc_m;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign w_rdata   = mem[w_addr];

  operand_fetch_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mem_rdata(mem_rdata), .x_reg(x), .y_reg(y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .pc(pc),
    .opcode(opcode), .imm(imm), .ea(ea),
    .ea_valid(ea_valid), .page_cross(page_cross),
    .ready(ready), .busy(busy),
    .fetch_cycles(fetch_cycles)
  );

  operand_fetch_seq #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .reset_n(reset_n), .start(w_start),
    .mem_rdata(w_rdata), .x_reg(x), .y_reg(y),
    .mem_rd(w_rd), .mem_addr(w_addr), .pc(w_pc),
    .opcode(w_opc), .imm(w_imm), .ea(w_ea),
    .ea_valid(w_eav), .page_cross(w_pgx),
    .ready(w_ready), .busy(w_busy),
    .fetch_cycles(w_cyc)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic int rd(input int a);
    return int'(mem[a % 65536]);
  endfunction

  // Reference: walk the instruction bytes with plain arithmetic
  function automatic exp_t model(input int pc0,
                                 input int xi,
                                 input int yi);
    exp_t e;
    int p, b1, b2, base, idx, t, mode, s;
    e = '{op: 8'h0, imm: 8'h0, ea: 16'h0, pc: 16'h0,
          ev: 1'b0, pcx: 1'b0, is_imm: 1'b0, cyc: 1};
    p = pc0;
    e.op = 8'(rd(p));
    p = (p + 1) % 65536;
    if (e.op[1:0] == 2'b01) begin
      mode = int'(e.op[4:2]);
      b1 = rd(p);
      p = (p + 1) % 65536;
      e.cyc = 2;
      e.ev = (mode != 2);
      case (mode)
        2: begin
          e.is_imm = 1'b1;
          e.imm = 8'(b1);
        end
        1: e.ea = 16'(b1);
        5: begin
          e.ea = 16'((b1 + xi) % 256);
          e.cyc = 3;
        end
        0: begin
          t = (b1 + xi) % 256;
          e.ea = 16'(rd(t) + 256 * rd((t + 1) % 256));
          e.cyc = 5;
        end
        4: begin
          base = rd(b1) + 256 * rd((b1 + 1) % 256);
          s = (base % 256) + yi;
          e.ea = 16'((base + yi) % 65536);
          e.pcx = (s > 255);
          e.cyc = e.pcx ? 5 : 4;
        end
        default: begin
          b2 = rd(p);
          p = (p + 1) % 65536;
          base = b1 + 256 * b2;
          idx = (mode == 3) ? 0 : (mode == 7) ? xi : yi;
          s = (base % 256) + idx;
          e.ea = 16'((base + idx) % 65536);
          e.pcx = (s > 255);
          e.cyc = e.pcx ? 4 : 3;
        end
      endcase
    end
    e.pc = 16'(p);
    return e;
  endfunction

  // Monitor: one comparison set per DONE entry
  initial begin
    automatic bit armed = 1'b1;
    automatic int bc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        armed = 1'b1;
        bc = 0;
      end else begin
        if (busy) bc++;
        if (!ready) begin
          armed = 1'b1;
        end else if (armed) begin
          armed = 1'b0;
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_ready: got 1 expected 0");
          end else begin
            e = sb.pop_front();
            chk("opcode", 32'(opcode), 32'(e.op));
            chk("pc", 32'(pc), 32'(e.pc));
            chk("ea_valid", 32'(ea_valid), 32'(e.ev));
            chk("page_cross", 32'(page_cross), 32'(e.pcx));
            chk("fetch_cycles", 32'(fetch_cycles), 32'(e.cyc));
            chk("busy_cycles", 32'(bc), 32'(e.cyc));
            if (e.is_imm) chk("imm", 32'(imm), 32'(e.imm));
            if (e.ev) chk("ea", 32'(ea), 32'(e.ea));
          end
          bc = 0;
        end
      end
    end
  end

  task automatic run(input bit hold);
    exp_t e;
    bit done;
    e = model(int'(pc_m), int'(x), int'(y));
    sb.push_back(e);
    pc_m = e.pc;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (ready) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      n_total++;
      $display("FAIL ready_timeout: got 0 expected 1");
      sb.delete();
    end
  endtask

  task automatic put(input logic [15:0] a,
                     input logic [7:0] d);
    mem[a] = d;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    w_start = 1'b0;
    x = 8'h0;
    y = 8'h0;
    pc_m = 16'h0600;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0600);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_imm", 32'(imm), 32'h0);
    chk("rst_ea", 32'(ea), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_flags",
        32'({mem_rd, ready, busy, ea_valid, page_cross}), 32'h0);
    chk("rst_cycles", 32'(fetch_cycles), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // LDA #$42
    put(16'h0600, 8'hA9); put(16'h0601, 8'h42);
    run(1'b0);
    chk("lda_imm_val", 32'(imm), 32'h42);
    chk("lda_imm_pc", 32'(pc), 32'h0602);

    // LDA $12F0,X with and without page cross
    put(16'h0602, 8'hBD); put(16'h0603, 8'hF0);
    put(16'h0604, 8'h12);
    x = 8'h20;
    run(1'b0);
    chk("abx_ea_cross", 32'(ea), 32'h1310);
    chk("abx_cyc_cross", 32'(fetch_cycles), 32'd4);
    put(16'h0605, 8'hBD); put(16'h0606, 8'hF0);
    put(16'h0607, 8'h12);
    x = 8'h05;
    run(1'b0);
    chk("abx_ea", 32'(ea), 32'h12F5);
    chk("abx_cyc", 32'(fetch_cycles), 32'd3);

    // LDA ($FF,X): pointer wraps inside page zero
    put(16'h0608, 8'hA1); put(16'h0609, 8'hFF);
    put(16'h0000, 8'h34); put(16'h0001, 8'h12);
    x = 8'h01;
    run(1'b0);
    chk("xind_ea", 32'(ea), 32'h1234);
    chk("xind_cyc", 32'(fetch_cycles), 32'd5);

    // LDA ($FF),Y with page cross
    put(16'h060A, 8'hB1); put(16'h060B, 8'hFF);
    put(16'h00FF, 8'hF8); put(16'h0000, 8'h20);
    y = 8'h10;
    run(1'b0);
    chk("indy_ea", 32'(ea), 32'h2108);
    chk("indy_pgx", 32'(page_cross), 32'd1);
    chk("indy_cyc", 32'(fetch_cycles), 32'd5);

    // Reset while in OP2 of an absolute fetch
    put(16'h060C, 8'hAD); put(16'h060D, 8'h00);
    put(16'h060E, 8'h30);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mf_op2_addr", 32'(mem_addr), 32'h060E);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mf_pc", 32'(pc), 32'h0600);
    chk("mf_ready", 32'(ready), 32'd0);
    chk("mf_busy", 32'(busy), 32'd0);
    chk("mf_addr", 32'(mem_addr), 32'h0);
    reset_n = 1'b1;
    pc_m = 16'h0600;
    put(16'h0600, 8'hAD); put(16'h0601, 8'h00);
    put(16'h0602, 8'h30);
    @(negedge clk);
    run(1'b0);
    chk("mf_refetch_ea", 32'(ea), 32'h3000);

    // Random instruction stream, sometimes back-to-back
    for (int n = 0; n < 200; n++) begin
      logic [7:0] op;
      op = 8'($urandom);
      if ($urandom_range(3) != 0) op[1:0] = 2'b01;
      mem[pc_m] = op;
      x = 8'($urandom);
      y = 8'($urandom);
      run($urandom_range(3) == 0);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // PC wrap with start held on an instance reset to FFFF
    put(16'hFFFF, 8'hEA); put(16'h0000, 8'hEA);
    put(16'h0001, 8'hEA);
    w_start = 1'b1;
    @(negedge clk);
    chk("wrap_opc_addr", 32'(w_addr), 32'hFFFF);
    chk("wrap_busy", 32'(w_busy), 32'd1);
    @(negedge clk);
    chk("wrap_ready", 32'(w_ready), 32'd1);
    chk("wrap_pc", 32'(w_pc), 32'h0000);
    chk("wrap_cyc", 32'(w_cyc), 32'd1);
    chk("wrap_eav", 32'(w_eav), 32'd0);
    @(negedge clk);
    chk("b2b_addr", 32'(w_addr), 32'h0000);
    chk("b2b_busy", 32'(w_busy), 32'd1);
    chk("b2b_noready", 32'(w_ready), 32'd0);
    @(negedge clk);
    chk("b2b_pc", 32'(w_pc), 32'h0001);
    chk("b2b_cyc", 32'(w_cyc), 32'd1);
    w_start = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
